cdp1802_dma_ctrl: RTL



---
 rtl/cdp1802_dma_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cdp1802_dma_ctrl.sv
// CDP1802 machine-cycle sequencer: TPA/TPB/SC generation, S2 DMA-out / S3 interrupt arbitration, R0 and IE ownership.
// SC changes at the phase-0 boundary only; DMA-in (S2-in) cycles exist only when CDP1802_DMA_IN_EN is defined.
module cdp1802_dma_ctrl #(
   parameter int CYCLE_CLKS = 8,
   parameter int TPA_PH     = 1,
   parameter int TPB_PH     = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        DMAO_n,
   input  logic        INT_n,
   input  logic        DMAI_n,
   input  logic        core_ack,
   input  logic        ie_set,
   input  logic        ie_clr,
   input  logic        r0_we,
   input  logic [15:0] r0_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic [7:0]  dma_in_data,
   output logic        TPA,
   output logic        TPB,
   output logic [1:0]  SC,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   output logic [7:0]  DataOut,
   output logic        core_en,
   output logic        int_ack,
   output logic [15:0] r0,
   output logic        ie
);

   localparam logic [3:0] PH_LAST = 4'(CYCLE_CLKS - 1);
   localparam logic [3:0] PH_TPA  = 4'(TPA_PH);
   localparam logic [3:0] PH_TPB  = 4'(TPB_PH);
   localparam logic [3:0] PH_CAP  = 4'(TPB_PH - 1);

   // Low two bits are the SC code; bit 2 tags the DMA-in flavour of SC=10.
   typedef enum logic [2:0] {
      ST_FETCH = 3'b000,
      ST_EXEC  = 3'b001,
      ST_DMAO  = 3'b010,
      ST_INT   = 3'b011,
      ST_DMAI  = 3'b110
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  phase;
   logic        last;
   logic        in_dma;
   logic        dma_pend;
   logic        int_pend;
   logic        dmai_pend;

   assign last   = (phase == PH_LAST);
   assign in_dma = (state == ST_DMAO) || (state == ST_DMAI);

   always_ff @(posedge clock) begin
      if (reset) begin
         phase <= 4'd0;
         state <= ST_FETCH;
      end else begin
         phase <= last ? 4'd0 : phase + 4'd1;
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (last) begin
         if (state == ST_FETCH || (state == ST_EXEC && !core_ack))
            state_nxt = ST_EXEC;
         else if (dmai_pend)
            state_nxt = ST_DMAI;
         else if (dma_pend)
            state_nxt = ST_DMAO;
         else if (int_pend && ie)
            state_nxt = ST_INT;
         else
            state_nxt = ST_FETCH;
      end
   end

   // Requests are sticky once seen at TPB and drop only when their cycle is entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         dma_pend <= 1'b0;
         int_pend <= 1'b0;
      end else begin
         if (phase == PH_TPB && !DMAO_n)
            dma_pend <= 1'b1;
         else if (last && state_nxt == ST_DMAO)
            dma_pend <= 1'b0;
         if (phase == PH_TPB && !INT_n)
            int_pend <= 1'b1;
         else if (last && state_nxt == ST_INT)
            int_pend <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         ie <= 1'b1;
      else if ((last && state_nxt == ST_INT) || (state == ST_INT && phase == 4'd0) || ie_clr)
         ie <= 1'b0;
      else if (ie_set)
         ie <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         r0 <= 16'h0000;
      else if (in_dma && last)
         r0 <= r0 + 16'h0001;
      else if (r0_we && core_en)
         r0 <= r0_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset)
         DataOut <= 8'h00;
      else if (state == ST_DMAO && phase == PH_CAP)
         DataOut <= mem_rdata;
   end

   assign TPA      = (phase == PH_TPA);
   assign TPB      = (phase == PH_TPB);
   assign SC       = state[1:0];
   assign core_en  = (state == ST_FETCH) || (state == ST_EXEC);
   assign int_ack  = (state == ST_INT) && (phase == 4'd0);
   assign mem_addr = in_dma ? r0 : 16'h0000;
   assign mem_rd   = (state == ST_DMAO) && (phase >= PH_TPA) && (phase <= PH_TPB);

`ifdef CDP1802_DMA_IN_EN
   always_ff @(posedge clock) begin
      if (reset)
         dmai_pend <= 1'b0;
      else if (phase == PH_TPB && !DMAI_n)
         dmai_pend <= 1'b1;
      else if (last && state_nxt == ST_DMAI)
         dmai_pend <= 1'b0;
   end

   assign mem_wr    = (state == ST_DMAI) && (phase == PH_TPB);
   assign mem_wdata = mem_wr ? dma_in_data : 8'h00;
`else
   logic unused_dmai;
   assign unused_dmai = ^{DMAI_n, dma_in_data};
   assign dmai_pend   = 1'b0;
   assign mem_wr      = 1'b0;
   assign mem_wdata   = 8'h00;
`endif

endmodule
